// File: rtl/program_loader.sv
// program_loader: byte-stream boot loader for the CPU instruction memory.
// Accepts packets of the form MAGIC, count[7:0], count[15:8], little-endian
// payload words, checksum byte. Each completed payload word is written to
// pc_mem, and the CPU is held in reset until a packet is accepted with a
// good checksum.
// Optional feature: define LOADER_TIMEOUT_EN to abort a packet to ERROR when
// no byte arrives for TIMEOUT_CYCLES cycles while a packet is in progress.
module program_loader #(
  parameter int          ADDR_W         = 13,
  parameter int          BASE_ADDR      = 0,
  parameter int          MAX_WORDS      = 8192,
  parameter logic [7:0]  MAGIC          = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset_low,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error,
  output logic [15:0]       words_loaded
);

  typedef enum logic [2:0] {
    IDLE, CNT_LO, CNT_HI, DATA, CHECK, DONE, ERROR
  } state_t;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  state_t      state, state_next;
  logic        ready_q;
  logic [15:0] count;
  logic [7:0]  sum;
  logic [1:0]  byte_idx;
  logic [23:0] shift;

  logic        accept;
  logic        is_magic;
  logic [7:0]  sum_plus;
  logic        last_word;
  logic        count_too_big;
  logic        count_zero;
  logic        timeout_hit;

  assign rx_ready      = ready_q;
  assign accept        = rx_valid & ready_q;
  assign is_magic      = (rx_data == MAGIC);
  assign sum_plus      = sum + rx_data;
  assign last_word     = ((words_loaded + 16'd1) == count);
  assign count_too_big = ({1'b0, rx_data, count[7:0]} > 17'(MAX_WORDS));
  assign count_zero    = ({rx_data, count[7:0]} == 16'd0);

`ifdef LOADER_TIMEOUT_EN
  logic [31:0] idle_cnt;
  logic        timer_active;

  assign timer_active = (state == CNT_LO) || (state == CNT_HI) ||
                        (state == DATA)   || (state == CHECK);
  assign timeout_hit  = timer_active && !accept &&
                        (idle_cnt == 32'(TIMEOUT_CYCLES - 1));

  // Inter-byte gap counter: restarts on each accepted byte, runs only mid-packet
  always_ff @(posedge clk) begin
    if (!reset_low) begin
      idle_cnt <= 32'd0;
    end else if (accept) begin
      idle_cnt <= 32'd0;
    end else if (timer_active) begin
      idle_cnt <= idle_cnt + 32'd1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign timeout_hit    = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!reset_low) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode on accepted bytes, plus status outputs derived from state
  always_comb begin
    state_next = state;
    cpu_hold   = 1'b1;
    load_done  = 1'b0;
    load_error = 1'b0;
    case (state)
      IDLE:   if (accept && is_magic) state_next = CNT_LO;
      CNT_LO: if (accept) state_next = CNT_HI;
      CNT_HI: begin
        if (accept) begin
          if (count_too_big)   state_next = ERROR;
          else if (count_zero) state_next = CHECK;
          else                 state_next = DATA;
        end
      end
      DATA:   if (accept && (byte_idx == 2'd3) && last_word) state_next = CHECK;
      CHECK:  if (accept) state_next = (sum_plus == 8'd0) ? DONE : ERROR;
      DONE: begin
        cpu_hold  = 1'b0;
        load_done = 1'b1;
        if (accept && is_magic) state_next = CNT_LO;
      end
      ERROR: begin
        load_error = 1'b1;
        if (accept && is_magic) state_next = CNT_LO;
      end
      default: state_next = IDLE;
    endcase
    if (timeout_hit) state_next = ERROR;
  end

  // Datapath: count capture, word assembly, checksum and the memory write strobe
  always_ff @(posedge clk) begin
    if (!reset_low) begin
      ready_q      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= BASE;
      mem_wdata    <= 32'd0;
      words_loaded <= 16'd0;
      count        <= 16'd0;
      sum          <= 8'd0;
      byte_idx     <= 2'd0;
      shift        <= 24'd0;
    end else begin
      ready_q <= 1'b1;
      mem_we  <= 1'b0;
      if (accept) begin
        case (state)
          IDLE, DONE, ERROR: begin
            if (is_magic) begin
              words_loaded <= 16'd0;
              sum          <= 8'd0;
              byte_idx     <= 2'd0;
            end
          end
          CNT_LO: count[7:0]  <= rx_data;
          CNT_HI: count[15:8] <= rx_data;
          DATA: begin
            sum      <= sum_plus;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              mem_we       <= 1'b1;
              mem_wdata    <= {rx_data, shift};
              mem_addr     <= BASE + ADDR_W'(words_loaded);
              words_loaded <= words_loaded + 16'd1;
            end else begin
              shift <= {rx_data, shift[23:8]};
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
